// File: rtl/im_loader_pkg.sv
// im_loader shared types: loader state encoding and header constants.
// Imported by im_loader and im_loader_shift.
package im_loader_pkg;

    localparam int HDR_W  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic [HDR_W-1:0] hdr_count(
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/im_loader_shift.sv
// Four-byte MSB-first word assembler; full_o flags the byte completing a word.
// The assembled word is presented combinationally together with that byte.
module im_loader_shift
    import im_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              full_o
);

    logic [23:0] word_q;
    logic [1:0]  cnt_q;

    assign word_o = {word_q, byte_i};
    assign full_o = en_i && (cnt_q == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (en_i) begin
            word_q <= word_o[23:0];
            cnt_q  <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Instruction-RAM loader: 16-bit word count header, then N big-endian words.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              Clk,
    input  logic              Clr_n,
    input  logic              Start,
    input  logic              In_valid,
    input  logic [7:0]        In_data,
    output logic              In_ready,
    output logic              Wr_en,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [WORD_W-1:0] Wr_data,
    output logic              Cpu_hold,
    output logic              Done,
    output logic              Err
);

    localparam logic [HDR_W:0] DEPTH_L = (HDR_W+1)'(DEPTH);

    state_e            state_q, state_d;
    logic [HDR_W-1:0]  n_q, n_d;
    logic [HDR_W-1:0]  widx_q, widx_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] xor_q, xor_d;
`endif

    logic              sh_clr;
    logic              sh_en;
    logic              sh_full;
    logic [WORD_W-1:0] sh_word;
    logic [HDR_W-1:0]  hdr_n;
    logic              hdr_bad;
    logic              last_word;

    assign sh_en = In_valid &&
                   (state_q == ST_DATA || state_q == ST_CHK);

    im_loader_shift u_shift (
        .clk_i  (Clk),
        .rst_ni (Clr_n),
        .clr_i  (sh_clr),
        .en_i   (sh_en),
        .byte_i (In_data),
        .word_o (sh_word),
        .full_o (sh_full)
    );

    assign hdr_n     = hdr_count(n_q[15:8], In_data);
    assign hdr_bad   = (hdr_n == '0) || ({1'b0, hdr_n} > DEPTH_L);
    assign last_word = (widx_q + 16'd1) == n_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        widx_d    = widx_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif
        sh_clr    = 1'b0;
        In_ready  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start) begin
                    state_d = ST_HDR0;
                    n_d     = '0;
                    widx_d  = '0;
                    sh_clr  = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            ST_HDR0: begin
                In_ready = 1'b1;
                if (In_valid) begin
                    n_d     = {In_data, 8'h00};
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                In_ready = 1'b1;
                if (In_valid) begin
                    n_d     = hdr_n;
                    state_d = hdr_bad ? ST_ERR : ST_DATA;
                end
            end
            ST_DATA: begin
                In_ready = 1'b1;
                if (sh_full) begin
                    wr_addr_d = widx_q[ADDR_W-1:0];
                    wr_data_d = sh_word;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                widx_d = widx_q + 16'd1;
`ifdef IM_LOADER_CHECKSUM_EN
                xor_d   = xor_q ^ wr_data_q;
                state_d = last_word ? ST_CHK : ST_DATA;
`else
                state_d = last_word ? ST_DONE : ST_DATA;
`endif
            end
`ifdef IM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                In_ready = 1'b1;
                if (sh_full) begin
                    state_d = (sh_word == xor_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            widx_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            widx_q    <= widx_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    // Cpu_hold drives the fetch stall and, ANDed with reset, the fetch clear.
    assign Cpu_hold = (state_q != ST_DONE);
    assign Wr_en    = (state_q == ST_WRITE);
    assign Done     = (state_q == ST_DONE);
    assign Err      = (state_q == ST_ERR);
    assign Wr_addr  = wr_addr_q;
    assign Wr_data  = wr_data_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: headers, writes, errors, reset, Start-ignore.
// Checksum cases are built only when IM_LOADER_CHECKSUM_EN is defined.
module tb_im_loader;

    logic        Clk = 1'b0;
    logic        Clr_n = 1'b0;
    logic        Start = 1'b0;
    logic        In_valid = 1'b0;
    logic [7:0]  In_data = 8'h00;
    logic        In_ready;
    logic        Wr_en;
    logic [9:0]  Wr_addr;
    logic [31:0] Wr_data;
    logic        Cpu_hold;
    logic        Done;
    logic        Err;

    int total = 0;
    int bad = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] exp_w[1024];

    im_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .Start    (Start),
        .In_valid (In_valid),
        .In_data  (In_data),
        .In_ready (In_ready),
        .Wr_en    (Wr_en),
        .Wr_addr  (Wr_addr),
        .Wr_data  (Wr_data),
        .Cpu_hold (Cpu_hold),
        .Done     (Done),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Wr_en) begin
            wa_q.push_back(Wr_addr);
            wd_q.push_back(Wr_data);
        end
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) @(negedge Clk);
        In_data  = b;
        In_valid = 1'b1;
        k = 0;
        while (!In_ready && k < 50) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 50) check("ready_timeout", 32'(In_ready), 1);
        @(negedge Clk);
        In_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
        end
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!Done && !Err && k < 40) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 40) check({tag, "_timeout"}, 32'(Done | Err), 1);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nerr;
        logic [31:0] x;

        // reset values
        #12;
        check("rst_ready", 32'(In_ready), 0);
        check("rst_wren", 32'(Wr_en), 0);
        check("rst_addr", 32'(Wr_addr), 0);
        check("rst_data", Wr_data, 0);
        check("rst_done", 32'(Done), 0);
        check("rst_err", 32'(Err), 0);
        check("rst_hold", 32'(Cpu_hold), 1);
        @(negedge Clk);
        Clr_n = 1'b1;
        @(negedge Clk);

        // basic two-word load
        clear_log();
        pulse_start();
        check("st_hold", 32'(Cpu_hold), 1);
        check("st_ready", 32'(In_ready), 1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h00003008, 0);
        send_word(32'h8C010004, 0);
`ifdef IM_LOADER_CHECKSUM_EN
        send_word(32'h8C01300C, 0);
`endif
        wait_end("two");
        check("two_cnt", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check("two_a0", 32'(wa_q[0]), 0);
            check("two_d0", wd_q[0], 32'h00003008);
            check("two_a1", 32'(wa_q[1]), 1);
            check("two_d1", wd_q[1], 32'h8C010004);
        end
        check("two_done", 32'(Done), 1);
        check("two_err", 32'(Err), 0);
        check("two_hold", 32'(Cpu_hold), 0);
        check("two_addr_hold", 32'(Wr_addr), 1);
        check("two_data_hold", Wr_data, 32'h8C010004);

        // Start during DATA is ignored
        clear_log();
        pulse_start();
        check("rs_done_clr", 32'(Done), 0);
        check("rs_hold", 32'(Cpu_hold), 1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 2);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
`ifdef IM_LOADER_CHECKSUM_EN
        send_word(32'hAABBCCDD, 0);
`endif
        wait_end("ign");
        check("ign_cnt", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            check("ign_a0", 32'(wa_q[0]), 0);
            check("ign_d0", wd_q[0], 32'hAABBCCDD);
        end
        check("ign_done", 32'(Done), 1);

        // N == 0 header
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("n0_err", 32'(Err), 1);
        check("n0_done", 32'(Done), 0);
        check("n0_hold", 32'(Cpu_hold), 1);
        check("n0_ready", 32'(In_ready), 0);
        repeat (3) @(negedge Clk);
        check("n0_nowr", wa_q.size(), 0);

        // N == 1025 header
        pulse_start();
        check("n1025_errclr", 32'(Err), 0);
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        check("n1025_err", 32'(Err), 1);
        check("n1025_nowr", wa_q.size(), 0);

        // N == 1024, random data and gaps
        clear_log();
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        check("nmax_hdr_ok", 32'(Err), 0);
        x = '0;
        for (int i = 0; i < 1024; i++) begin
            exp_w[i] = $urandom;
            x ^= exp_w[i];
            send_word(exp_w[i], 2);
        end
`ifdef IM_LOADER_CHECKSUM_EN
        send_word(x, 1);
`endif
        wait_end("nmax");
        repeat (3) @(negedge Clk);
        check("nmax_cnt", wa_q.size(), 1024);
        nerr = 0;
        for (int i = 0; i < wa_q.size() && i < 1024; i++) begin
            if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_w[i]) nerr++;
        end
        check("nmax_seq", nerr, 0);
        check("nmax_done", 32'(Done), 1);
        check("nmax_last", 32'(Wr_addr), 1023);

        // reset mid-load, then a fresh load
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h01020304, 0);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        Clr_n = 1'b0;
        #1;
        check("mr_ready", 32'(In_ready), 0);
        check("mr_wren", 32'(Wr_en), 0);
        check("mr_addr", 32'(Wr_addr), 0);
        check("mr_data", Wr_data, 0);
        check("mr_done", 32'(Done), 0);
        check("mr_err", 32'(Err), 0);
        check("mr_hold", 32'(Cpu_hold), 1);
        @(negedge Clk);
        Clr_n = 1'b1;
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'h11223344, 1);
`ifdef IM_LOADER_CHECKSUM_EN
        send_word(32'h11223344, 0);
`endif
        wait_end("mr");
        check("mr_cnt", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            check("mr_a0", 32'(wa_q[0]), 0);
            check("mr_d0", wd_q[0], 32'h11223344);
        end
        check("mr_fin", 32'(Done), 1);

`ifdef IM_LOADER_CHECKSUM_EN
        // checksum good and bad
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h12345678, 0);
        send_word(32'h0F0F0F0F, 0);
        send_word(32'h1D3B5977, 0);
        wait_end("ck_good");
        check("ck_good_done", 32'(Done), 1);
        check("ck_good_cnt", wa_q.size(), 2);
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h12345678, 0);
        send_word(32'h0F0F0F0F, 0);
        send_word(32'h00000000, 0);
        wait_end("ck_bad");
        check("ck_bad_err", 32'(Err), 1);
        check("ck_bad_hold", 32'(Cpu_hold), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction-RAM word-address width.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning the maximum loadable word count (2^ADDR_W).
REQ-003 SHALL have ports: Clk  in  1  rising-edge clock.
REQ-004 SHALL have Clr_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have Start  in  1  single-cycle request to begin a load.
REQ-006 SHALL have In_valid  in  1  byte-stream valid.
REQ-007 SHALL have In_data  in  8  byte-stream data.
REQ-008 SHALL have In_ready  out  1  byte-stream ready; a byte transfers on a clock edge where In_valid and In_ready are both 1.
REQ-009 SHALL have Wr_en  out  1  instruction-RAM write strobe.
REQ-010 SHALL have Wr_addr  out  ADDR_W  instruction-RAM word address.
REQ-011 SHALL have Wr_data  out  32  instruction-RAM write word.
REQ-012 SHALL have Cpu_hold  out  1  holds the fetch unit in stall/clear while 1.
REQ-013 SHALL have Done  out  1  load completed successfully.
REQ-014 SHALL have Err  out  1  load aborted on a protocol error.

Function
REQ-015 SHALL implement the states IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE and ERR.
REQ-016 SHALL go from IDLE, DONE or ERR to HDR0 on Start=1; Start SHALL be ignored in every other state.
REQ-017 SHALL drive In_ready=1 only in HDR0, HDR1, DATA and CHK.
REQ-018 SHALL take the header as the first byte (HDR0) = N[15:8] and the second byte (HDR1) = N[7:0], with N being the 16-bit word count.
REQ-019 SHALL go from HDR1 to ERR when N==0 or N>DEPTH, and to DATA otherwise.
REQ-020 SHALL assemble DATA bytes MSB-first: byte0 -> [31:24], ..., byte3 -> [7:0].
REQ-021 SHALL go to WRITE after the 4th byte of a word; WRITE lasts exactly one cycle with Wr_en=1, Wr_addr=word index (starting at 0) and Wr_data=the assembled word.
REQ-022 SHALL leave WRITE for DATA when words written < N; on the Nth word it SHALL go to CHK if IM_LOADER_CHECKSUM_EN is defined, else to DONE.
REQ-023 SHALL hold Wr_en=0 in every state other than WRITE; Wr_addr and Wr_data SHALL hold their last values between writes.
REQ-024 SHALL keep the word index at N-1 or below, never wrapping past DEPTH-1, because N is limited to DEPTH.
REQ-025 SHALL set Done=1 and Cpu_hold=0 in DONE, and Err=1 and Cpu_hold=1 in ERR.
REQ-026 SHALL clear Done and Err and set Cpu_hold=1 on the cycle after accepting Start.
REQ-027 SHALL not time out on a stalled stream (In_valid=0); byte position and counters SHALL hold.
REQ-028 SHALL leave already-written words in RAM when a load is restarted or aborted; there is no erase.

Reset
REQ-029 SHALL, while Clr_n=0, force state IDLE, In_ready=0, Wr_en=0, Wr_addr=0, Wr_data=0, Done=0, Err=0, Cpu_hold=1 and clear all counters, at any time including mid-load.
REQ-030 SHALL hold Cpu_hold=1 from reset until DONE is reached.

Configuration
REQ-031 SHALL use the macro IM_LOADER_CHECKSUM_EN.
REQ-032 SHALL, with IM_LOADER_CHECKSUM_EN defined, keep a running XOR of all written words, receive 4 further bytes in CHK (MSB-first), go to DONE if they match the XOR and to ERR otherwise.
REQ-033 SHALL, with IM_LOADER_CHECKSUM_EN undefined, omit the CHK state and the XOR register, so that CHK is never entered.

Structure
REQ-034 SHALL place the state encoding (enum typedef) and the header width constant (16) in the shared package im_loader_pkg.
REQ-035 SHALL contain one sub-module, im_loader_shift, a 4-byte MSB-first word assembler with byte counter and word-complete flag.
REQ-036 SHALL connect Cpu_hold at top level to the fetch unit's stall input and, qualified with reset, to its clear input.

Verification
REQ-037 SHALL cover: reset, then Start, then header 00 02 and bytes 00 00 30 08, 8C 01 00 04 -> Wr_en pulses at addr 0 with 0x00003008 and at addr 1 with 0x8C010004; Done=1, Cpu_hold=0.
REQ-038 SHALL cover: header 00 00 -> Err=1, Cpu_hold=1, no Wr_en pulse; header 04 01 (N=1025) -> Err=1.
REQ-039 SHALL cover: N=1024 with a random stream and random In_valid gaps -> 1024 writes at addresses 0..1023 in order, with no write past 1023.
REQ-040 SHALL cover: Clr_n pulsed low after 6 data bytes -> all outputs at reset values immediately; a following Start with a fresh load succeeds.
REQ-041 SHALL cover, with CHECKSUM_EN: words 0x12345678 and 0x0F0F0F0F followed by checksum 1D 3B 59 77 -> Done=1; with checksum 00 00 00 00 -> Err=1.
REQ-042 SHALL cover: Start asserted during DATA -> ignored, and the load completes normally.
